// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending transaction sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [7:0] COIN_UNIT = 8'd5;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 8'd5;
            COIN_10: return 8'd10;
            COIN_20: return 8'd20;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter with a zero flag; shared by the ack watchdog and change spacing.
module vend_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, price check, dispense handshake with
// watchdog refund, and change return as spaced 5-unit pulses.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 20,
    parameter int PRICE2      = 25,
    parameter int PRICE3      = 30,
    parameter int BAL_MAX     = 95,
    parameter int ACK_TIMEOUT = 64,
    parameter int CHG_GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [1:0] disp_id,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       err_funds,
    output logic       fault,
    output logic       busy,
    output logic [7:0] balance
);

    localparam int TW = $clog2(ACK_TIMEOUT + CHG_GAP + 1);

    if ((PRICE0 % 5) != 0 || PRICE0 < 5 || PRICE0 > BAL_MAX ||
        (PRICE1 % 5) != 0 || PRICE1 < 5 || PRICE1 > BAL_MAX ||
        (PRICE2 % 5) != 0 || PRICE2 < 5 || PRICE2 > BAL_MAX ||
        (PRICE3 % 5) != 0 || PRICE3 < 5 || PRICE3 > BAL_MAX ||
        BAL_MAX > 255 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("vend_controller: prices must be multiples of 5 within 5..BAL_MAX");
    end

    function automatic logic [7:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    return 8'(PRICE0);
            2'd1:    return 8'(PRICE1);
            2'd2:    return 8'(PRICE2);
            default: return 8'(PRICE3);
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   balance_q, balance_d;
    logic         disp_req_q, disp_req_d;
    logic [1:0]   disp_id_q, disp_id_d;
    logic         change_pulse_q, change_pulse_d;
    logic         coin_reject_q, coin_reject_d;
    logic         err_funds_q, err_funds_d;
    logic         fault_q, fault_d;

    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic [8:0]    bal_sum;
    logic [7:0]    sel_price;

    vend_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign bal_sum   = {1'b0, balance_q} + {1'b0, coin_value(coin_code)};
    assign sel_price = price_of(sel_id);

    always_comb begin
        state_d        = state_q;
        balance_d      = balance_q;
        disp_req_d     = disp_req_q;
        disp_id_d      = disp_id_q;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        err_funds_d    = 1'b0;
        fault_d        = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        tmr_dec        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_valid && coin_code != COIN_NONE) begin
                    // A valid coin wins arbitration even when it is refused for overflow
                    if (bal_sum <= 9'(BAL_MAX))
                        balance_d = bal_sum[7:0];
                    else
                        coin_reject_d = 1'b1;
                end else begin
                    if (coin_valid)
                        coin_reject_d = 1'b1;
                    if (cancel) begin
                        if (balance_q != 8'd0) begin
                            state_d  = ST_CHANGE;
                            tmr_load = 1'b1;
                        end
                    end else if (sel_valid) begin
                        if (balance_q >= sel_price) begin
                            balance_d  = balance_q - sel_price;
                            disp_req_d = 1'b1;
                            disp_id_d  = sel_id;
                            state_d    = ST_VEND;
                            tmr_load   = 1'b1;
                            tmr_val    = TW'(ACK_TIMEOUT - 1);
                        end else begin
                            err_funds_d = 1'b1;
                        end
                    end
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    if (balance_q != 8'd0) begin
                        state_d  = ST_CHANGE;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_zero) begin
                    // Watchdog expired: restore the price and refund everything
                    disp_req_d = 1'b0;
                    fault_d    = 1'b1;
                    balance_d  = balance_q + price_of(disp_id_q);
                    state_d    = ST_CHANGE;
                    tmr_load   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (balance_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    change_pulse_d = 1'b1;
                    balance_d      = balance_q - COIN_UNIT;
                    tmr_load       = 1'b1;
                    tmr_val        = TW'(CHG_GAP);
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            balance_q      <= 8'd0;
            disp_req_q     <= 1'b0;
            disp_id_q      <= 2'd0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_funds_q    <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            balance_q      <= balance_d;
            disp_req_q     <= disp_req_d;
            disp_id_q      <= disp_id_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            err_funds_q    <= err_funds_d;
            fault_q        <= fault_d;
        end
    end

    assign disp_req     = disp_req_q;
    assign disp_id      = disp_id_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign err_funds    = err_funds_q;
    assign fault        = fault_q;
    assign busy         = (state_q != ST_IDLE);
    assign balance      = balance_q;

endmodule
